csr_file_mx: RTL and testbench



---
 rtl/csr_file_mx.sv | 239 +++++++++++++++++++++++
 tb/tb_csr_file_mx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_mx.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause with trap and mret sequencing.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file_mx #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [1:0]      op_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic            instret_i,
  output logic [XLEN-1:0] rdata_o,
  output logic [XLEN-1:0] mie_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_en_o,
  output logic            illegal_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SET   = 2'b11;

  // mepc is always 4-byte aligned
  localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(3);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rdata;
  logic            mapped;
  logic            read_only;
  logic [XLEN-1:0] wval;
  logic            sw_we;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_MCYCLE      = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET    = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH     = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH   = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE_RO    = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET_RO  = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH_RO   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH_RO = 12'hC82;

  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        cyc_wr_lo, cyc_wr_hi;
  logic        ins_wr_lo, ins_wr_hi;

  // A written half replaces that half; the counter skips its increment and the other
  // half is left alone (no carry out of the written half).
  function automatic logic [63:0] cnt_next(input logic [63:0]     cur,
                                           input logic            inc,
                                           input logic            wr_lo,
                                           input logic            wr_hi,
                                           input logic [XLEN-1:0] val);
    logic [63:0] nxt;
    nxt = cur;
    if (wr_lo) begin
      if (XLEN == 32) begin
        nxt[31:0] = val[31:0];
      end else begin
        nxt = 64'(val);
      end
    end else if (wr_hi) begin
      nxt[63:32] = val[31:0];
    end else if (inc) begin
      nxt = cur + 64'd1;
    end
    return nxt;
  endfunction
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  assign mstatus_rd = XLEN'({mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});

  // Address decode and combinational read
  always_comb begin
    rdata     = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (addr_i)
      ADDR_MSTATUS:  rdata = mstatus_rd;
      ADDR_MIE:      rdata = mie_q;
      ADDR_MTVEC:    rdata = mtvec_q;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_q;
      ADDR_MCAUSE:   rdata = mcause_q;
`ifdef CSR_COUNTERS_EN
      ADDR_MCYCLE, ADDR_CYCLE_RO: begin
        rdata     = XLEN'(mcycle_q);
        read_only = (addr_i == ADDR_CYCLE_RO);
      end
      ADDR_MINSTRET, ADDR_INSTRET_RO: begin
        rdata     = XLEN'(minstret_q);
        read_only = (addr_i == ADDR_INSTRET_RO);
      end
      ADDR_MCYCLEH, ADDR_CYCLEH_RO: begin
        if (XLEN == 32) begin
          rdata     = XLEN'(mcycle_q[63:32]);
          read_only = (addr_i == ADDR_CYCLEH_RO);
        end else begin
          mapped = 1'b0;
        end
      end
      ADDR_MINSTRETH, ADDR_INSTRETH_RO: begin
        if (XLEN == 32) begin
          rdata     = XLEN'(minstret_q[63:32]);
          read_only = (addr_i == ADDR_INSTRETH_RO);
        end else begin
          mapped = 1'b0;
        end
      end
`endif
      default: mapped = 1'b0;
    endcase
  end

  assign rdata_o   = rdata;
  assign illegal_o = (op_i != OP_NONE) && (!mapped || read_only);

  always_comb begin
    unique case (op_i)
      OP_WRITE: wval = wdata_i;
      OP_CLEAR: wval = rdata & ~wdata_i;
      OP_SET:   wval = rdata | wdata_i;
      default:  wval = rdata;
    endcase
  end

  // Trap discards every software write; mret only discards the mstatus write.
  assign sw_we = (op_i != OP_NONE) && !illegal_o && !trap_i;

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;

    if (sw_we) begin
      case (addr_i)
        ADDR_MSTATUS: begin
          if (!mret_i) begin
            mstatus_mie_d  = wval[3];
            mstatus_mpie_d = wval[7];
          end
        end
        ADDR_MIE:      mie_d      = wval;
        ADDR_MTVEC:    mtvec_d    = wval;
        ADDR_MSCRATCH: mscratch_d = wval;
        ADDR_MEPC:     mepc_d     = wval & EPC_MASK;
        ADDR_MCAUSE:   mcause_d   = wval;
        default: ;
      endcase
    end

    if (trap_i) begin
      mepc_d         = pc_i & EPC_MASK;
      mcause_d       = mcause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

`ifdef CSR_COUNTERS_EN
  always_comb begin
    cyc_wr_lo  = sw_we && (addr_i == ADDR_MCYCLE);
    cyc_wr_hi  = sw_we && (addr_i == ADDR_MCYCLEH);
    ins_wr_lo  = sw_we && (addr_i == ADDR_MINSTRET);
    ins_wr_hi  = sw_we && (addr_i == ADDR_MINSTRETH);
    mcycle_d   = cnt_next(mcycle_q, 1'b1, cyc_wr_lo, cyc_wr_hi, wval);
    minstret_d = cnt_next(minstret_q, instret_i, ins_wr_lo, ins_wr_hi, wval);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
    end
  end

  assign mie_o    = mie_q;
  assign mtvec_o  = mtvec_q;
  assign mepc_o   = mepc_q;
  assign irq_en_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file_mx.sv
// Self-checking bench for csr_file_mx (XLEN = 32): vector table with a scoreboard queue,
// plus hand sequences for counters and reset overriding a trap.
module tb_csr_file_mx;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  op_i;
  logic        trap_i;
  logic        mret_i;
  logic [31:0] pc_i;
  logic [31:0] mcause_i;
  logic        instret_i;
  logic [31:0] rdata_o;
  logic [31:0] mie_o;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        irq_en_o;
  logic        illegal_o;

  csr_file_mx #(
    .XLEN        (32),
    .MTVEC_RESET (MTVEC_RST)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .op_i      (op_i),
    .trap_i    (trap_i),
    .mret_i    (mret_i),
    .pc_i      (pc_i),
    .mcause_i  (mcause_i),
    .instret_i (instret_i),
    .rdata_o   (rdata_o),
    .mie_o     (mie_o),
    .mtvec_o   (mtvec_o),
    .mepc_o    (mepc_o),
    .irq_en_o  (irq_en_o),
    .illegal_o (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  op;
    logic        trap;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] cause;
    logic        exp_ill;
    logic [11:0] chk_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  typedef struct {
    int          idx;
    logic [11:0] chk_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [1:0] op, input logic trap, input logic mret,
                              input logic [31:0] pc, input logic [31:0] cause,
                              input logic exp_ill, input logic [11:0] chk_addr,
                              input logic [31:0] exp_rd, input logic exp_irq);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.op = op; v.trap = trap; v.mret = mret;
    v.pc = pc; v.cause = cause; v.exp_ill = exp_ill; v.chk_addr = chk_addr;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic idle_inputs();
    op_i = 2'b00; trap_i = 1'b0; mret_i = 1'b0; wdata_i = '0;
    pc_i = '0; mcause_i = '0; instret_i = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    addr_i = addr;
    #1;
    check(name, 64'(rdata_o), 64'(exp));
  endtask

  initial begin
    sb_t e;
    rst_i  = 1'b1;
    addr_i = '0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state
    read_chk("rst mtvec", 12'h305, MTVEC_RST);
    read_chk("rst mstatus", 12'h300, 32'h0);
    check("rst irq_en", 64'(irq_en_o), 64'd0);
    check("rst mie_o", 64'(mie_o), 64'd0);
    check("rst mepc_o", 64'(mepc_o), 64'd0);
    check("rst mtvec_o", 64'(mtvec_o), 64'(MTVEC_RST));

    //            addr    wdata         op    trp   mrt   pc            cause         ill   chk     exp           irq
    vecs.push_back(mk(12'h300, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h88, 1'b1));
    vecs.push_back(mk(12'h300, 32'h8, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h80, 1'b0));
    vecs.push_back(mk(12'h300, 32'h8, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h88, 1'b1));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b1, 1'b0, 32'h1003, 32'h8000_000B, 1'b0, 12'h341,
                      32'h1000, 1'b0));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h342,
                      32'h8000_000B, 1'b0));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h80, 1'b0));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 12'h300, 32'h88, 1'b1));
    vecs.push_back(mk(12'h340, 32'hAA, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h340, 32'hAA, 1'b1));
    // trap beats a same-cycle software write
    vecs.push_back(mk(12'h340, 32'h55, 2'b01, 1'b1, 1'b0, 32'h2000, 32'h7, 1'b0, 12'h340, 32'hAA, 1'b0));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h341, 32'h2000, 1'b0));
    // trap beats mret: MPIE <= MIE (0)
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b1, 1'b1, 32'h3006, 32'h3, 1'b0, 12'h300, 32'h00, 1'b0));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h341, 32'h3004, 1'b0));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 12'h300, 32'h80, 1'b0));
    // mret with a non-mstatus write: both commit
    vecs.push_back(mk(12'h304, 32'h888, 2'b01, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 12'h304, 32'h888, 1'b1));
    vecs.push_back(mk(12'h000, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h88, 1'b1));
    // mret with an mstatus write: write dropped
    vecs.push_back(mk(12'h300, 32'h0, 2'b01, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 12'h300, 32'h88, 1'b1));
    vecs.push_back(mk(12'h7C0, 32'h123, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 12'h340, 32'hAA, 1'b1));
    vecs.push_back(mk(12'hC00, 32'h5, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 12'h7C0, 32'h0, 1'b1));
    vecs.push_back(mk(12'h341, 32'h1234_5677, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h341,
                      32'h1234_5674, 1'b1));
    vecs.push_back(mk(12'h305, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h305,
                      32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(12'h342, 32'h8000_0000, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h342,
                      32'h8000_0003, 1'b1));
    vecs.push_back(mk(12'h304, 32'h8, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h304, 32'h880, 1'b1));
    vecs.push_back(mk(12'h7C0, 32'h1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h305,
                      32'hFFFF_FFFF, 1'b1));

    foreach (vecs[i]) begin
      @(negedge clk_i);
      addr_i = vecs[i].addr; wdata_i = vecs[i].wdata; op_i = vecs[i].op;
      trap_i = vecs[i].trap; mret_i = vecs[i].mret; pc_i = vecs[i].pc; mcause_i = vecs[i].cause;
      #1;
      check($sformatf("vec%0d illegal", i), 64'(illegal_o), 64'(vecs[i].exp_ill));
      sb_q.push_back('{idx: i, chk_addr: vecs[i].chk_addr, exp_rd: vecs[i].exp_rd,
                       exp_irq: vecs[i].exp_irq});
      @(posedge clk_i);
      #1;
      idle_inputs();
      e = sb_q.pop_front();
      addr_i = e.chk_addr;
      #1;
      check($sformatf("vec%0d rdata", e.idx), 64'(rdata_o), 64'(e.exp_rd));
      check($sformatf("vec%0d irq_en", e.idx), 64'(irq_en_o), 64'(e.exp_irq));
    end

    check("out mtvec_o", 64'(mtvec_o), 64'hFFFF_FFFF);
    check("out mie_o", 64'(mie_o), 64'h880);
    check("out mepc_o", 64'(mepc_o), 64'h1234_5674);

`ifdef CSR_COUNTERS_EN
    // Low-half write, then carry into the high half on the following increment
    @(negedge clk_i);
    addr_i = 12'hB00; wdata_i = 32'hFFFF_FFFF; op_i = 2'b01;
    #1;
    check("cyc wr illegal", 64'(illegal_o), 64'd0);
    @(posedge clk_i);
    #1;
    idle_inputs();
    read_chk("cyc lo after wr", 12'hB00, 32'hFFFF_FFFF);
    read_chk("cyc hi after wr", 12'hB80, 32'h0);
    @(posedge clk_i);
    #1;
    read_chk("cyc lo carry", 12'hB00, 32'h0);
    read_chk("cyc hi carry", 12'hC80, 32'h1);
    @(negedge clk_i);
    addr_i = 12'hB02; wdata_i = 32'h5; op_i = 2'b01; instret_i = 1'b1;
    @(posedge clk_i);
    #1;
    op_i = 2'b00;
    read_chk("instret wr", 12'hB02, 32'h5);
    repeat (2) @(posedge clk_i);
    #1;
    instret_i = 1'b0;
    read_chk("instret count", 12'hC02, 32'h7);
    @(negedge clk_i);
    addr_i = 12'hC02; op_i = 2'b01; wdata_i = 32'h0;
    #1;
    check("instret ro illegal", 64'(illegal_o), 64'd1);
    @(posedge clk_i);
    #1;
    idle_inputs();
    read_chk("instret ro kept", 12'hB02, 32'h7);
`else
    @(negedge clk_i);
    addr_i = 12'hB00; wdata_i = 32'h1234; op_i = 2'b01;
    #1;
    check("no-cnt illegal", 64'(illegal_o), 64'd1);
    @(posedge clk_i);
    #1;
    idle_inputs();
    read_chk("no-cnt read", 12'hB00, 32'h0);
`endif

    // Reset on the same edge as a trap and a write
    @(negedge clk_i);
    rst_i = 1'b1; trap_i = 1'b1; pc_i = 32'h4000; mcause_i = 32'h9;
    addr_i = 12'h340; wdata_i = 32'h77; op_i = 2'b01;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle_inputs();
    read_chk("rst-ovr mscratch", 12'h340, 32'h0);
    read_chk("rst-ovr mepc", 12'h341, 32'h0);
    read_chk("rst-ovr mcause", 12'h342, 32'h0);
    read_chk("rst-ovr mstatus", 12'h300, 32'h0);
    check("rst-ovr irq_en", 64'(irq_en_o), 64'd0);
    check("rst-ovr mtvec_o", 64'(mtvec_o), 64'(MTVEC_RST));
    check("rst-ovr mie_o", 64'(mie_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
